// File: rtl/c2c_shim_pipe_if.sv
// c2c request/response bus bundle: flattened read and write channels.
// The shim uses the slave modport toward the core and the master modport toward memory.
interface c2c_shim_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NUM_R = 2,
  parameter int unsigned NUM_W = 1
);
  localparam int unsigned SW = XLEN / 8;

  logic [NUM_R-1:0]      rd_re;
  logic [NUM_R*SW-1:0]   rd_sel;
  logic [NUM_R*XLEN-1:0] rd_addr;
  logic [NUM_R-1:0]      rd_ack;
  logic [NUM_R*XLEN-1:0] rd_data;

  logic [NUM_W-1:0]      wr_we;
  logic [NUM_W*SW-1:0]   wr_sel;
  logic [NUM_W*XLEN-1:0] wr_addr;
  logic [NUM_W*XLEN-1:0] wr_data;
  logic [NUM_W-1:0]      wr_ack;

  modport master (
    output rd_re, rd_sel, rd_addr, wr_we, wr_sel, wr_addr, wr_data,
    input  rd_ack, rd_data, wr_ack
  );

  modport slave (
    input  rd_re, rd_sel, rd_addr, wr_we, wr_sel, wr_addr, wr_data,
    output rd_ack, rd_data, wr_ack
  );
endinterface

// File: rtl/c2c_shim_pipe.sv
// Parametrised c2c shim: one-entry request buffer per read/write channel, all outputs registered.
// Optional per-channel memory-ack watchdog enabled by defining C2C_SHIM_TIMEOUT_EN.
module c2c_shim_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_R   = 2,
  parameter int unsigned NUM_W   = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  c2c_shim_pipe_if.slave         core,
  c2c_shim_pipe_if.master        mem,
  output logic [NUM_R+NUM_W-1:0] timeout
);
  localparam int unsigned SW = XLEN / 8;
`ifdef C2C_SHIM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("c2c_shim_pipe: XLEN must be 32 or 64");
  end
  if (NUM_R < 1 || NUM_R > 8 || NUM_W < 1 || NUM_W > 4 || TIMEOUT < 1) begin : g_bad_cfg
    $error("c2c_shim_pipe: channel count or TIMEOUT out of range");
  end

  // Read channels: hold sel/addr on memory side until ack, return data with a one-cycle ack.
  for (genvar g = 0; g < NUM_R; g++) begin : g_rd
    state_t            r_state;
    logic              r_re;
    logic              r_ack;
    logic [SW-1:0]     r_sel;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_data;
`ifdef C2C_SHIM_TIMEOUT_EN
    logic [CW-1:0]     r_cnt;
    logic              r_to;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_re    <= 1'b0;
        r_ack   <= 1'b0;
        r_sel   <= '0;
        r_addr  <= '0;
        r_data  <= '0;
`ifdef C2C_SHIM_TIMEOUT_EN
        r_cnt   <= '0;
        r_to    <= 1'b0;
`endif
      end else begin
        r_ack <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (core.rd_re[g]) begin
              r_sel   <= core.rd_sel[g*SW +: SW];
              r_addr  <= core.rd_addr[g*XLEN +: XLEN];
              r_re    <= 1'b1;
              r_state <= ST_REQ;
`ifdef C2C_SHIM_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end
          end
          ST_REQ: begin
            if (mem.rd_ack[g]) begin
              r_data  <= mem.rd_data[g*XLEN +: XLEN];
              r_re    <= 1'b0;
              r_ack   <= 1'b1;
              r_state <= ST_RESP;
            end
`ifdef C2C_SHIM_TIMEOUT_EN
            else if (r_cnt == CW'(TIMEOUT - 1)) begin
              r_data  <= '1;
              r_re    <= 1'b0;
              r_ack   <= 1'b1;
              r_to    <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
`endif
          end
          ST_RESP: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    assign mem.rd_re[g]                   = r_re;
    assign mem.rd_sel[g*SW +: SW]         = r_sel;
    assign mem.rd_addr[g*XLEN +: XLEN]    = r_addr;
    assign core.rd_ack[g]                 = r_ack;
    assign core.rd_data[g*XLEN +: XLEN]   = r_data;
`ifdef C2C_SHIM_TIMEOUT_EN
    assign timeout[g]                     = r_to;
`endif
  end

  // Write channels: hold sel/addr/data on memory side until ack.
  for (genvar g = 0; g < NUM_W; g++) begin : g_wr
    state_t            r_state;
    logic              r_we;
    logic              r_ack;
    logic [SW-1:0]     r_sel;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_data;
`ifdef C2C_SHIM_TIMEOUT_EN
    logic [CW-1:0]     r_cnt;
    logic              r_to;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_we    <= 1'b0;
        r_ack   <= 1'b0;
        r_sel   <= '0;
        r_addr  <= '0;
        r_data  <= '0;
`ifdef C2C_SHIM_TIMEOUT_EN
        r_cnt   <= '0;
        r_to    <= 1'b0;
`endif
      end else begin
        r_ack <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (core.wr_we[g]) begin
              r_sel   <= core.wr_sel[g*SW +: SW];
              r_addr  <= core.wr_addr[g*XLEN +: XLEN];
              r_data  <= core.wr_data[g*XLEN +: XLEN];
              r_we    <= 1'b1;
              r_state <= ST_REQ;
`ifdef C2C_SHIM_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end
          end
          ST_REQ: begin
            if (mem.wr_ack[g]) begin
              r_we    <= 1'b0;
              r_ack   <= 1'b1;
              r_state <= ST_RESP;
            end
`ifdef C2C_SHIM_TIMEOUT_EN
            else if (r_cnt == CW'(TIMEOUT - 1)) begin
              r_we    <= 1'b0;
              r_ack   <= 1'b1;
              r_to    <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
`endif
          end
          ST_RESP: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    assign mem.wr_we[g]                   = r_we;
    assign mem.wr_sel[g*SW +: SW]         = r_sel;
    assign mem.wr_addr[g*XLEN +: XLEN]    = r_addr;
    assign mem.wr_data[g*XLEN +: XLEN]    = r_data;
    assign core.wr_ack[g]                 = r_ack;
`ifdef C2C_SHIM_TIMEOUT_EN
    assign timeout[NUM_R+g]               = r_to;
`endif
  end

`ifndef C2C_SHIM_TIMEOUT_EN
  assign timeout = '0;
`endif

endmodule

// File: tb/tb_c2c_shim_pipe.sv
// Self-checking bench for c2c_shim_pipe (XLEN=32, NUM_R=2, NUM_W=1, TIMEOUT=4).
// Memory side is played by the bench; expectations follow the transaction timing rules.
module tb_c2c_shim_pipe;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] timeout;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd [2];

  c2c_shim_pipe_if #(.XLEN(32), .NUM_R(2), .NUM_W(1)) core_if ();
  c2c_shim_pipe_if #(.XLEN(32), .NUM_R(2), .NUM_W(1)) mem_if ();

  c2c_shim_pipe #(.XLEN(32), .NUM_R(2), .NUM_W(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .core(core_if.slave), .mem(mem_if.master), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read on channel ch; memory acks during the (dly+1)-th REQ cycle.
  task automatic rd_txn(input int ch, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, input int dly, input bit hold_re);
    core_if.rd_re[ch] = 1'b1;
    core_if.rd_addr[ch*32 +: 32] = addr;
    core_if.rd_sel[ch*4 +: 4] = sel;
    tick();
    core_if.rd_re[ch] = hold_re;
    for (int i = 0; i <= dly; i++) begin
      chk("rd_mem_re", 64'(mem_if.rd_re[ch]), 64'd1);
      chk("rd_mem_addr", 64'(mem_if.rd_addr[ch*32 +: 32]), 64'(addr));
      chk("rd_mem_sel", 64'(mem_if.rd_sel[ch*4 +: 4]), 64'(sel));
      chk("rd_core_ack_wait", 64'(core_if.rd_ack[ch]), 64'd0);
      core_if.rd_addr[ch*32 +: 32] = $urandom;
      mem_if.rd_data[ch*32 +: 32] = $urandom;
      if (i == dly) begin
        mem_if.rd_ack[ch] = 1'b1;
        mem_if.rd_data[ch*32 +: 32] = data;
      end
      tick();
    end
    mem_if.rd_ack[ch] = 1'b0;
    mem_if.rd_data[ch*32 +: 32] = $urandom;
    exp_rd[ch] = data;
    chk("rd_core_ack", 64'(core_if.rd_ack[ch]), 64'd1);
    chk("rd_core_data", 64'(core_if.rd_data[ch*32 +: 32]), 64'(data));
    chk("rd_mem_re_resp", 64'(mem_if.rd_re[ch]), 64'd0);
    tick();
    core_if.rd_re[ch] = 1'b0;
    chk("rd_core_ack_after", 64'(core_if.rd_ack[ch]), 64'd0);
    chk("rd_no_rereq", 64'(mem_if.rd_re[ch]), 64'd0);
    chk("rd_data_hold", 64'(core_if.rd_data[ch*32 +: 32]), 64'(data));
  endtask

  task automatic wr_txn(input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, input int dly, input bit hold_we);
    core_if.wr_we[0] = 1'b1;
    core_if.wr_addr = addr;
    core_if.wr_sel = sel;
    core_if.wr_data = data;
    tick();
    core_if.wr_we[0] = hold_we;
    for (int i = 0; i <= dly; i++) begin
      chk("wr_mem_we", 64'(mem_if.wr_we[0]), 64'd1);
      chk("wr_mem_addr", 64'(mem_if.wr_addr), 64'(addr));
      chk("wr_mem_sel", 64'(mem_if.wr_sel), 64'(sel));
      chk("wr_mem_data", 64'(mem_if.wr_data), 64'(data));
      chk("wr_core_ack_wait", 64'(core_if.wr_ack[0]), 64'd0);
      core_if.wr_addr = $urandom;
      core_if.wr_data = $urandom;
      if (i == dly) mem_if.wr_ack[0] = 1'b1;
      tick();
    end
    mem_if.wr_ack[0] = 1'b0;
    chk("wr_core_ack", 64'(core_if.wr_ack[0]), 64'd1);
    chk("wr_mem_we_resp", 64'(mem_if.wr_we[0]), 64'd0);
    tick();
    core_if.wr_we[0] = 1'b0;
    chk("wr_core_ack_after", 64'(core_if.wr_ack[0]), 64'd0);
    chk("wr_no_rereq", 64'(mem_if.wr_we[0]), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    core_if.rd_re = '0; core_if.rd_sel = '0; core_if.rd_addr = '0;
    core_if.wr_we = '0; core_if.wr_sel = '0; core_if.wr_addr = '0; core_if.wr_data = '0;
    mem_if.rd_ack = '0; mem_if.rd_data = '0; mem_if.wr_ack = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    tick(); tick();
    chk("rst_mem_rd_re", 64'(mem_if.rd_re), 64'd0);
    chk("rst_mem_wr_we", 64'(mem_if.wr_we), 64'd0);
    chk("rst_core_rd_data", 64'(core_if.rd_data), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    reset = 1'b0;
    tick();

    // Immediate-ack read and stalled read with core address changing mid-wait.
    rd_txn(0, 32'h100, 4'hF, 32'hDEADBEEF, 0, 1'b0);
    rd_txn(0, 32'h200, 4'hF, 32'h0BADF00D, 5, 1'b1);

    // Stray memory ack while idle is ignored.
    mem_if.rd_ack[0] = 1'b1;
    mem_if.rd_data[31:0] = 32'h55AA55AA;
    tick();
    mem_if.rd_ack[0] = 1'b0;
    chk("stray_core_ack", 64'(core_if.rd_ack[0]), 64'd0);
    chk("stray_data_hold", 64'(core_if.rd_data[31:0]), 64'(exp_rd[0]));
    tick();
    chk("stray_core_ack2", 64'(core_if.rd_ack[0]), 64'd0);
    chk("stray_mem_re", 64'(mem_if.rd_re[0]), 64'd0);

    // Concurrent write on w0 and read on r1, completing at different cycles.
    core_if.wr_we[0] = 1'b1; core_if.wr_addr = 32'h40; core_if.wr_data = 32'h12345678;
    core_if.wr_sel = 4'h3;
    core_if.rd_re[1] = 1'b1; core_if.rd_addr[63:32] = 32'h500; core_if.rd_sel[7:4] = 4'hF;
    tick();
    core_if.wr_we[0] = 1'b0; core_if.rd_re[1] = 1'b0;
    chk("cc_mem_we", 64'(mem_if.wr_we[0]), 64'd1);
    chk("cc_mem_re1", 64'(mem_if.rd_re[1]), 64'd1);
    chk("cc_mem_wdata", 64'(mem_if.wr_data), 64'h12345678);
    chk("cc_mem_wsel", 64'(mem_if.wr_sel), 64'h3);
    chk("cc_mem_raddr1", 64'(mem_if.rd_addr[63:32]), 64'h500);
    mem_if.wr_ack[0] = 1'b1;
    tick();
    mem_if.wr_ack[0] = 1'b0;
    chk("cc_core_wack", 64'(core_if.wr_ack[0]), 64'd1);
    chk("cc_rd1_pending", 64'(mem_if.rd_re[1]), 64'd1);
    chk("cc_core_rack_early", 64'(core_if.rd_ack[1]), 64'd0);
    mem_if.rd_ack[1] = 1'b1; mem_if.rd_data[63:32] = 32'hCAFEF00D;
    tick();
    mem_if.rd_ack[1] = 1'b0;
    exp_rd[1] = 32'hCAFEF00D;
    chk("cc_core_rack", 64'(core_if.rd_ack[1]), 64'd1);
    chk("cc_core_rdata", 64'(core_if.rd_data[63:32]), 64'hCAFEF00D);
    chk("cc_core_wack_done", 64'(core_if.wr_ack[0]), 64'd0);
    tick();

    // Ack on the watchdog's final REQ cycle still completes normally.
    rd_txn(1, 32'h600, 4'h1, 32'h11223344, 3, 1'b0);
    chk("ack_wins_timeout", 64'(timeout), 64'd0);

    // Randomised transactions across all channels.
    for (int n = 0; n < 30; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      if (kind == 2)
        wr_txn($urandom, 4'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
      else
        rd_txn(kind, $urandom, 4'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end
    chk("rand_timeout", 64'(timeout), 64'd0);

    // Memory never acks a read on r0.
    core_if.rd_re[0] = 1'b1; core_if.rd_addr[31:0] = 32'h700;
    tick();
    core_if.rd_re[0] = 1'b0;
`ifdef C2C_SHIM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("wd_mem_re", 64'(mem_if.rd_re[0]), 64'd1);
      chk("wd_core_ack_wait", 64'(core_if.rd_ack[0]), 64'd0);
      tick();
    end
    chk("wd_core_ack", 64'(core_if.rd_ack[0]), 64'd1);
    chk("wd_data", 64'(core_if.rd_data[31:0]), 64'hFFFFFFFF);
    chk("wd_flag", 64'(timeout), 64'b001);
    tick(); tick();
    chk("wd_sticky", 64'(timeout), 64'b001);
    chk("wd_ack_done", 64'(core_if.rd_ack[0]), 64'd0);
`else
    for (int i = 0; i < 10; i++) begin
      chk("nowd_mem_re", 64'(mem_if.rd_re[0]), 64'd1);
      chk("nowd_core_ack", 64'(core_if.rd_ack[0]), 64'd0);
      chk("nowd_timeout", 64'(timeout), 64'd0);
      tick();
    end
    mem_if.rd_ack[0] = 1'b1; mem_if.rd_data[31:0] = 32'h0F0F0F0F;
    tick();
    mem_if.rd_ack[0] = 1'b0;
    chk("nowd_core_ack_late", 64'(core_if.rd_ack[0]), 64'd1);
    chk("nowd_data", 64'(core_if.rd_data[31:0]), 64'h0F0F0F0F);
    tick();
`endif

    // Asynchronous reset while a write is outstanding.
    core_if.wr_we[0] = 1'b1; core_if.wr_addr = 32'h80; core_if.wr_data = 32'hA5A5A5A5;
    core_if.wr_sel = 4'hF;
    tick();
    core_if.wr_we[0] = 1'b0;
    chk("rst_pre_we", 64'(mem_if.wr_we[0]), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_we", 64'(mem_if.wr_we[0]), 64'd0);
    chk("rst_async_waddr", 64'(mem_if.wr_addr), 64'd0);
    chk("rst_async_wdata", 64'(mem_if.wr_data), 64'd0);
    chk("rst_async_rdata", 64'(core_if.rd_data), 64'd0);
    chk("rst_async_timeout", 64'(timeout), 64'd0);
    mem_if.wr_ack[0] = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    mem_if.wr_ack[0] = 1'b0;
    chk("rst_late_ack", 64'(core_if.wr_ack[0]), 64'd0);
    chk("rst_late_we", 64'(mem_if.wr_we[0]), 64'd0);
    tick();
    chk("rst_late_ack2", 64'(core_if.wr_ack[0]), 64'd0);

    // Shim works normally after reset.
    wr_txn(32'h90, 4'hC, 32'h600DF00D, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/c2c_shim_pipe.md
# c2c_shim_pipe

Parametrised request/response shim between the core's c2c master ports and flattened memory-side c2c ports, succeeding the fixed three-bus core shim. It provides NUM_R read channels and NUM_W write channels, each with a one-entry request buffer. The buffer holds address, select and data stable on the memory side until acknowledged, and returns a registered ack and data to the core. It sits at the core boundary, between core and bus fabric or test harness.

## Interface
- XLEN, 32, address/data width; must be 32 or 64
- NUM_R, 2, read channel count (channel 0 is instruction fetch), 1..8
- NUM_W, 1, write channel count, 1..4
- TIMEOUT, 255, memory-ack watchdog limit in cycles; used only with the watchdog macro

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- core_r_re / core_r_sel / core_r_addr  in  NUM_R / NUM_R*XLEN/8 / NUM_R*XLEN  core read requests
- core_r_ack / core_r_data  out  NUM_R / NUM_R*XLEN  read completion to core
- core_w_we / core_w_sel / core_w_addr / core_w_data  in  NUM_W / NUM_W*XLEN/8 / NUM_W*XLEN / NUM_W*XLEN  core write requests
- core_w_ack  out  NUM_W  write completion to core
- mem_r_re / mem_r_sel / mem_r_addr  out  NUM_R / NUM_R*XLEN/8 / NUM_R*XLEN  memory-side read requests
- mem_r_ack / mem_r_data  in  NUM_R / NUM_R*XLEN  memory read completion
- mem_w_we / mem_w_sel / mem_w_addr / mem_w_data  out  as core-side  memory-side write requests
- mem_w_ack  in  NUM_W  memory write completion
- timeout  out  NUM_R+NUM_W  sticky per-channel watchdog flag; read channels occupy the low bits

## Operation
- Each channel runs an independent FSM: IDLE -> REQ -> RESP -> IDLE.
- IDLE
  - core re/we high at a clock edge: capture sel/addr (and data for writes) into the channel registers and go to REQ.
  - Otherwise stay in IDLE.
- REQ
  - mem re/we = 1; held sel/addr/data are driven and stay constant throughout REQ.
  - mem ack high: read channels capture mem_r_data; go to RESP.
- RESP
  - core ack = 1 for exactly one cycle; core_r_data is valid for that cycle.
  - Core request inputs are ignored in RESP, because the core still shows the completed request during that cycle.
  - Always returns to IDLE.
- mem ack while the channel is in IDLE or RESP: ignored.
- core_r_data holds its last captured value outside RESP. No reset clear is required beyond reset itself, which zeroes it.
- Channels never interact. Simultaneous events on different channels are fully independent.
- Reset, including mid-transaction: every FSM goes to IDLE; all outputs, held registers and timeout flags go to 0. An in-flight memory access is abandoned, and its later ack is ignored.

## Timing
- Core request sampled at edge 0 -> mem re high from cycle 1.
- mem ack sampled at edge k (k ≥ 1) -> core ack high during cycle k+1.
- Minimum core-request-to-core-ack latency is 2 cycles.
- Back-to-back throughput on a channel is one transaction per 3 cycles minimum: IDLE, REQ, RESP.
- Every output is a flop output; there are no combinational paths from inputs to outputs.

## Configuration
- C2C_SHIM_TIMEOUT_EN defined:
  - Each channel has a counter that clears on entry to REQ and increments every cycle spent in REQ.
  - When the count reaches TIMEOUT with no mem ack, the channel goes to RESP. A read returns all-ones data. The channel's timeout bit is set and stays set until reset.
  - A mem ack on the same edge as the timeout wins: normal completion, and the flag is not set.
- C2C_SHIM_TIMEOUT_EN undefined:
  - No counters are built.
  - The timeout output is tied to 0.
  - A channel waits in REQ indefinitely.

## Test plan
- Read, immediate ack: core_r_re[0]=1, addr 0x100, sel 0xF at edge 0; mem_r_ack[0]=1, data 0xDEADBEEF during cycle 1 -> core_r_ack[0]=1 and core_r_data=0xDEADBEEF in cycle 2 only; mem_r_re[0] high in cycle 1 only.
- Stall hold: read at addr 0x200 with mem ack delayed 5 cycles; core addr changed to 0x300 mid-wait -> mem_r_addr stays 0x200 for all REQ cycles; core ack arrives one cycle after mem ack.
- Write plus concurrent read: write addr 0x40, data 0x12345678, sel 0x3 on channel w0, issued on the same edge as a read on r1 -> both memory sides assert in cycle 1; acks at different cycles complete independently with correct values.
- Stray and RESP-cycle inputs: mem_r_ack pulsed in IDLE -> no core ack. core re still high during RESP -> no second mem request until the core re-asserts in IDLE.
- Reset mid-REQ: assert reset while mem_w_we=1 -> all outputs 0 immediately (asynchronous). A mem ack after reset is released -> no core ack.
- Watchdog (macro defined, TIMEOUT=4): read with no mem ack -> core ack with data 0xFFFFFFFF after 4 REQ cycles, timeout[0]=1 sticky. Macro undefined -> channel stays in REQ and timeout stays 0.
